// File: rtl/serial_adder_seq.sv
// rtl/serial_adder_seq.sv - bit-serial adder stage with valid/ready handshakes on both sides
// Optional subtract mode (a-b, c_out=1 means no borrow) enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [CW-1:0]    count;
  logic             bit_a;
  logic             bit_b;
  logic             bit_s;
  logic             bit_c;
  logic             accept;
  logic             last_step;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q;
  assign bit_b = b_sr[0] ^ sub_q;
`else
  assign bit_b = b_sr[0];
`endif

  assign bit_a     = a_sr[0];
  assign bit_s     = bit_a ^ bit_b ^ carry;
  assign bit_c     = (bit_a & bit_b) | (carry & (bit_a ^ bit_b));
  assign res_nxt   = {bit_s, res_sr[WIDTH-1:1]};
  assign accept    = (state == IDLE) && in_valid;
  assign last_step = (state == RUN) && (count == LAST);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (count == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum    <= '0;
      c_out  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q  <= 1'b0;
`endif
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      count <= '0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q <= sub;
      carry <= sub ? 1'b1 : cin;
`else
      carry <= cin;
`endif
    end else if (state == RUN) begin
      // sum bits enter from the MSB side so the first bit lands in bit0 after WIDTH steps
      res_sr <= res_nxt;
      carry  <= bit_c;
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      count  <= count + 1'b1;
      if (last_step) begin
        sum   <= res_nxt;
        c_out <= bit_c;
      end
    end
  end

endmodule
